// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the CDC FIFO self-test pair (write-side pattern
// source and read-side checker). Both ends advance the pattern with
// pat_next(), so they generate the same sequence.
package cdc_fifo_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef enum logic {MODE_CNT = 1'b0, MODE_LFSR = 1'b1} mode_e;

  // Feedback taps at bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] pat_next(input mode_e m, input logic [7:0] v);
    return (m == MODE_LFSR) ? lfsr8_next(v) : v + 8'd1;
  endfunction

endpackage

// File: rtl/pat_gen.sv
// Pattern generator: holds the current pattern word.
//   clk, rst  : clock, synchronous active-high reset
//   load/seed : load a new first word (LFSR mode maps seed 0 to 8'h01,
//               because the all-zero state would lock up the LFSR)
//   advance   : step to the next word of the selected pattern
//   mode      : counter or LFSR
//   value     : current pattern word
module pat_gen
  import cdc_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  input  mode_e      mode,
  output logic [7:0] value
);

  always_ff @(posedge clk) begin
    if (rst)          value <= 8'h00;
    else if (load)    value <= (mode == MODE_LFSR && seed == 8'h00) ? 8'h01 : seed;
    else if (advance) value <= pat_next(mode, value);
  end

endmodule

// File: rtl/fifo_rd_checker.sv
// Read-side consumer of the CDC FIFO. Pops NUM_WORDS words and compares each
// against a locally regenerated pattern; reports pass/fail, error count,
// first bad word and stall timeout.
//   clk, rst          : read clock, synchronous active-high reset
//   start, mode, seed : run control (start accepted in IDLE/DONE only)
//   rd_empty, rd_data : FIFO read port (data valid the cycle after a pop)
//   rd_en             : pop request, combinational, never high while empty
//   busy, done, pass, timeout, err_cnt, word_cnt, first_bad : status
module fifo_rd_checker
  import cdc_fifo_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] seed,
  input  logic       rd_empty,
  input  logic [7:0] rd_data,
  output logic       rd_en,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] err_cnt,
  output logic [7:0] word_cnt,
  output logic [7:0] first_bad
);

  localparam logic [7:0]  NW = 8'(NUM_WORDS);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_e      state, state_nxt;
  mode_e       mode_q, pat_mode;
  logic [7:0]  issued, exp_val;
  logic [15:0] stall;
  logic        cmp_vld, start_acc, stall_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    start_acc = 1'b0;
    stall_hit = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        start_acc = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        rd_en = !rd_empty && (issued < NW);
        if (rd_en && issued == NW - 8'd1) state_nxt = DRAIN;
        // this cycle is the TIMEOUT-th consecutive cycle without a pop
        else if (!rd_en && stall == TO - 16'd1) begin
          stall_hit = 1'b1;
          state_nxt = DONE;
        end
      end
      DRAIN:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // The mode input is only meaningful at load; afterwards use the latched copy
  assign pat_mode = start_acc ? mode_e'(mode) : mode_q;

  pat_gen u_pat (
    .clk     (clk),
    .rst     (rst),
    .load    (start_acc),
    .seed    (seed),
    .advance (cmp_vld),
    .mode    (pat_mode),
    .value   (exp_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_CNT;
      issued    <= 8'd0;
      stall     <= 16'd0;
      cmp_vld   <= 1'b0;
      err_cnt   <= 8'd0;
      word_cnt  <= 8'd0;
      first_bad <= 8'd0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      cmp_vld <= rd_en;
      // status flags decode the current state, so they lag it by one edge
      busy    <= (state == RUN) || (state == DRAIN);
      done    <= (state == DONE);
      pass    <= (state == DONE) && (err_cnt == 8'd0) && !timeout;
      if (start_acc) begin
        mode_q    <= mode_e'(mode);
        issued    <= 8'd0;
        stall     <= 16'd0;
        err_cnt   <= 8'd0;
        word_cnt  <= 8'd0;
        first_bad <= 8'd0;
        timeout   <= 1'b0;
      end else begin
        if (rd_en) begin
          issued <= issued + 8'd1;
          stall  <= 16'd0;
        end else if (state == RUN) begin
          stall  <= stall + 16'd1;
        end
        if (stall_hit) timeout <= 1'b1;
        // start is only accepted in IDLE/DONE where no compare is in flight
        if (cmp_vld) begin
          word_cnt <= word_cnt + 8'd1;
          if (rd_data != exp_val) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (err_cnt == 8'd0)  first_bad <= rd_data;
          end
        end
      end
    end
  end

endmodule
